// File: rtl/intr_ctrl_if.sv
// Processor-side port bundle of the interrupt controller: bus address/direction
// strobes plus the interrupt request and latched source ID.
interface intr_ctrl_if #(
    parameter int unsigned DBITS  = 32,
    parameter int unsigned IDBITS = 3
);
    logic [DBITS-1:0]  abus;
    logic              we;
    logic              irq;
    logic [IDBITS-1:0] irq_id;

    modport master (output abus, output we, input irq, input irq_id);
    modport slave  (input abus, input we, output irq, output irq_id);
endinterface

// File: rtl/intr_ctrl.sv
// Memory-mapped priority interrupt controller: samples level-sensitive device
// lines, raises one irq, and holds the serviced ID until end-of-interrupt.
module intr_ctrl #(
    parameter int unsigned       DBITS     = 32,
    parameter int unsigned       NSRC      = 8,
    parameter int unsigned       IDBITS    = 3,
    parameter logic [DBITS-1:0]  ID_ADDR   = DBITS'(32'hF000_0400),
    parameter logic [DBITS-1:0]  MASK_ADDR = DBITS'(32'hF000_0410),
    parameter logic [DBITS-1:0]  PEND_ADDR = DBITS'(32'hF000_0420),
    parameter logic [DBITS-1:0]  CTRL_ADDR = DBITS'(32'hF000_0430),
    parameter logic [DBITS-1:0]  EOI_ADDR  = DBITS'(32'hF000_0440)
) (
    input  logic              clk,
    input  logic              init,
    intr_ctrl_if.slave        bus,
    inout  wire  [DBITS-1:0]  dbus,
    input  logic [NSRC-1:0]   dev_intr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    logic              irq;
    logic [IDBITS-1:0] irq_id;
    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   mask;
    logic              gie;

    logic [NSRC-1:0]   elig;
    logic [IDBITS-1:0] sel;
    logic              elig_cur;
    logic              rd_id;
    logic              mask_wr;
    logic              ctrl_wr;
    logic              eoi_wr;
    logic              rd_hit;
    logic [DBITS-1:0]  rdata;
    logic              unused_wdata;

    assign elig     = gie ? (pend & mask) : '0;
    assign elig_cur = |(elig & (NSRC'(1) << irq_id));

    assign rd_id   = !bus.we && (bus.abus == ID_ADDR);
    assign mask_wr =  bus.we && (bus.abus == MASK_ADDR);
    assign ctrl_wr =  bus.we && (bus.abus == CTRL_ADDR);
    assign eoi_wr  =  bus.we && (bus.abus == EOI_ADDR);

    // Lowest-numbered eligible source has priority.
    always_comb begin
        sel = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (elig[i]) sel = IDBITS'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!init) begin
            state  <= IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
            pend   <= '0;
            mask   <= '0;
            gie    <= 1'b0;
        end else begin
            pend <= dev_intr;
            if (mask_wr) mask <= dbus[NSRC-1:0];
            if (ctrl_wr) gie  <= dbus[0];

            case (state)
                IDLE: begin
                    irq <= 1'b0;
                    if (|elig) begin
                        state  <= REQ;
                        irq_id <= sel;
                        irq    <= 1'b1;
                    end
                end
                REQ: begin
                    // Acknowledge beats a simultaneous withdrawal.
                    if (rd_id) begin
                        state <= SERVICE;
                        irq   <= 1'b0;
                    end else if (!elig_cur) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end else begin
                        irq   <= 1'b1;
                    end
                end
                SERVICE: begin
                    irq <= 1'b0;
                    if (eoi_wr) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; the ID register reads all-ones as a spurious marker when idle.
    always_comb begin
        rd_hit = 1'b0;
        rdata  = '0;
        if (!bus.we) begin
            case (bus.abus)
                ID_ADDR: begin
                    rd_hit = 1'b1;
                    rdata  = (state == IDLE) ? '1 : DBITS'(irq_id);
                end
                MASK_ADDR: begin
                    rd_hit = 1'b1;
                    rdata  = DBITS'(mask);
                end
                PEND_ADDR: begin
                    rd_hit = 1'b1;
                    rdata  = DBITS'(pend);
                end
                CTRL_ADDR: begin
                    rd_hit = 1'b1;
                    rdata  = DBITS'({state, 3'b000, gie});
                end
                default: ;
            endcase
        end
    end

    assign dbus         = rd_hit ? rdata : {DBITS{1'bz}};
    assign unused_wdata = ^dbus;

    assign bus.irq    = irq;
    assign bus.irq_id = irq_id;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: bus reads/writes through the interface and
// hand-computed expectations checked with immediate assertions.
module tb_intr_ctrl;

    localparam logic [31:0] ID_ADDR   = 32'hF000_0400;
    localparam logic [31:0] MASK_ADDR = 32'hF000_0410;
    localparam logic [31:0] PEND_ADDR = 32'hF000_0420;
    localparam logic [31:0] CTRL_ADDR = 32'hF000_0430;
    localparam logic [31:0] EOI_ADDR  = 32'hF000_0440;
    localparam logic [31:0] SPURIOUS  = 32'hFFFF_FFFF;

    logic        clk;
    logic        init;
    logic [7:0]  dev_intr;
    logic        tb_oe;
    logic [31:0] tb_wd;
    wire  [31:0] dbus;

    int checks;
    int errors;

    intr_ctrl_if bus ();

    assign dbus = tb_oe ? tb_wd : {32{1'bz}};

    intr_ctrl dut (
        .clk      (clk),
        .init     (init),
        .bus      (bus),
        .dbus     (dbus),
        .dev_intr (dev_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Side-effect-free read: sampled between edges, bus parked before next edge.
    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.abus = addr;
        bus.we   = 1'b0;
        tb_oe    = 1'b0;
        #1;
        data     = dbus;
        bus.abus = 32'h0;
    endtask

    // ID read held across one clock edge (acknowledge).
    task automatic ack(output logic [31:0] data);
        bus.abus = ID_ADDR;
        bus.we   = 1'b0;
        tb_oe    = 1'b0;
        #1;
        data = dbus;
        tick();
        bus.abus = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.abus = addr;
        bus.we   = 1'b1;
        tb_wd    = data;
        tb_oe    = 1'b1;
        tick();
        bus.we   = 1'b0;
        tb_oe    = 1'b0;
        bus.abus = 32'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        checks   = 0;
        errors   = 0;
        init     = 1'b0;
        dev_intr = 8'h00;
        tb_oe    = 1'b0;
        tb_wd    = 32'h0;
        bus.abus = 32'h0;
        bus.we   = 1'b0;

        // Reset then idle
        tick(); tick();
        init = 1'b1;
        tick();
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_irq_id", 32'(bus.irq_id), 32'h0);
        chk_rd("rst_id", ID_ADDR, SPURIOUS);
        chk_rd("rst_mask", MASK_ADDR, 32'h0);
        chk_rd("rst_ctrl", CTRL_ADDR, 32'h0);

        // Basic flow
        wr(MASK_ADDR, 32'h01);
        wr(CTRL_ADDR, 32'h01);
        chk_rd("basic_mask", MASK_ADDR, 32'h01);
        chk_rd("basic_ctrl_gie", CTRL_ADDR, 32'h01);
        dev_intr = 8'h01;
        tick();
        chk("basic_irq_e0", 32'(bus.irq), 32'h0);
        tick();
        chk("basic_irq_e1", 32'(bus.irq), 32'h1);
        chk("basic_id_pin", 32'(bus.irq_id), 32'h0);
        chk_rd("basic_ctrl_req", CTRL_ADDR, 32'h11);
        ack(d);
        chk("basic_ack_id", d, 32'h0);
        chk("basic_irq_ack", 32'(bus.irq), 32'h0);
        chk_rd("basic_ctrl_svc", CTRL_ADDR, 32'h21);
        ack(d);
        chk("basic_ack_hold", d, 32'h0);
        chk_rd("basic_ctrl_svc2", CTRL_ADDR, 32'h21);
        wr(EOI_ADDR, 32'h0);
        chk_rd("basic_ctrl_eoi", CTRL_ADDR, 32'h01);
        chk("basic_irq_eoi", 32'(bus.irq), 32'h0);
        tick();
        chk("basic_irq_reassert", 32'(bus.irq), 32'h1);
        ack(d);
        dev_intr = 8'h00;
        wr(EOI_ADDR, 32'h0);
        tick();
        chk("basic_quiet", 32'(bus.irq), 32'h0);

        // Priority and freeze
        wr(MASK_ADDR, 32'hFF);
        dev_intr = 8'h20;
        tick(); tick();
        chk("prio_irq", 32'(bus.irq), 32'h1);
        chk("prio_id5", 32'(bus.irq_id), 32'h5);
        dev_intr = 8'h24;
        tick(); tick();
        chk("prio_frozen", 32'(bus.irq_id), 32'h5);
        chk_rd("prio_ctrl_req", CTRL_ADDR, 32'h11);
        ack(d);
        chk("prio_ack_id5", d, 32'h5);
        dev_intr = 8'h04;
        wr(EOI_ADDR, 32'h0);
        tick();
        chk("prio_next_irq", 32'(bus.irq), 32'h1);
        chk("prio_next_id2", 32'(bus.irq_id), 32'h2);

        // Withdrawal by dropped line (2 drops, 3 takes over)
        dev_intr = 8'h08;
        tick(); tick();
        chk("wd_drop_irq", 32'(bus.irq), 32'h0);
        tick();
        chk("wd_id3", 32'(bus.irq_id), 32'h3);
        chk("wd_irq3", 32'(bus.irq), 32'h1);
        dev_intr = 8'h00;
        tick(); tick();
        chk("wd_line_irq", 32'(bus.irq), 32'h0);
        chk_rd("wd_line_id", ID_ADDR, SPURIOUS);
        chk_rd("wd_line_ctrl", CTRL_ADDR, 32'h01);

        // Withdrawal by clearing GIE
        dev_intr = 8'h08;
        tick(); tick();
        chk("wd_gie_req", 32'(bus.irq), 32'h1);
        wr(CTRL_ADDR, 32'h0);
        tick();
        chk("wd_gie_irq", 32'(bus.irq), 32'h0);
        chk_rd("wd_gie_id", ID_ADDR, SPURIOUS);
        chk_rd("wd_gie_ctrl", CTRL_ADDR, 32'h00);

        // Masking and global enable
        dev_intr = 8'h0F;
        wr(MASK_ADDR, 32'h00);
        wr(CTRL_ADDR, 32'h01);
        tick(); tick();
        chk("mask_none_irq", 32'(bus.irq), 32'h0);
        chk_rd("mask_pend", PEND_ADDR, 32'h0F);
        wr(PEND_ADDR, 32'h0);
        chk_rd("mask_pend_ro", PEND_ADDR, 32'h0F);
        wr(MASK_ADDR, 32'h08);
        tick();
        chk("mask_id3", 32'(bus.irq_id), 32'h3);
        chk("mask_irq", 32'(bus.irq), 32'h1);
        wr(CTRL_ADDR, 32'h0);
        tick(); tick();
        chk("gie_off_irq", 32'(bus.irq), 32'h0);

        // Acknowledge on the same edge as a withdrawal
        wr(CTRL_ADDR, 32'h01);
        tick();
        chk("race_req", 32'(bus.irq), 32'h1);
        dev_intr = 8'h00;
        tick();
        ack(d);
        chk("race_ack_id", d, 32'h3);
        chk_rd("race_ctrl_svc", CTRL_ADDR, 32'h21);
        tick();
        chk_rd("race_svc_stable", CTRL_ADDR, 32'h21);
        wr(EOI_ADDR, 32'h0);
        wr(EOI_ADDR, 32'h0);
        chk_rd("eoi_idle_ignored", CTRL_ADDR, 32'h01);

        // Reset mid-service
        dev_intr = 8'h02;
        wr(MASK_ADDR, 32'h02);
        tick();
        chk("rstsvc_id1", 32'(bus.irq_id), 32'h1);
        ack(d);
        chk("rstsvc_ack", d, 32'h1);
        chk_rd("rstsvc_ctrl", CTRL_ADDR, 32'h21);
        init = 1'b0;
        tick();
        init = 1'b1;
        chk_rd("rstsvc_ctrl0", CTRL_ADDR, 32'h00);
        chk_rd("rstsvc_mask0", MASK_ADDR, 32'h00);
        chk("rstsvc_irq", 32'(bus.irq), 32'h0);
        chk("rstsvc_irq_id", 32'(bus.irq_id), 32'h0);
        wr(EOI_ADDR, 32'h0);
        tick();
        chk_rd("rstsvc_eoi", CTRL_ADDR, 32'h00);
        chk("rstsvc_quiet", 32'(bus.irq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Memory-mapped priority interrupt controller on the abus/dbus I/O bus.
- Collects level-sensitive intr lines from I/O devices (keys, switches, timer, ...) and presents a single irq to the processor.
- Holds the ID of the source being serviced until software signals end-of-interrupt.
- Sequences interrupt delivery: request, acknowledge by ID read, service, EOI. Serves one interrupt at a time, with no nesting.

Parameters:
DBITS, 32, bus address/data width
NSRC, 8, number of interrupt sources (1..2^IDBITS)
IDBITS, 3, width of a source ID
ID_ADDR, 32'hF0000400, read: current interrupt ID (acknowledge)
MASK_ADDR, 32'hF0000410, R/W: per-source enable, bits [NSRC-1:0]
PEND_ADDR, 32'hF0000420, R: sampled source lines, bits [NSRC-1:0]
CTRL_ADDR, 32'hF0000430, R/W: bit0 GIE (global enable); read-only bits [5:4] state code
EOI_ADDR, 32'hF0000440, write (any data): end of interrupt

Ports:
clk  input  1  system clock, all state on posedge
init  input  1  synchronous reset, active-low (asserted when 0)
abus  input  DBITS  bus address
dbus  inout  DBITS  bus data; driven only on reads of own addresses, else high-Z
we  input  1  bus write enable (1 = write, 0 = read)
dev_intr  input  NSRC  device interrupt lines, level-sensitive, active-high
irq  output  1  interrupt request to processor, registered
irq_id  output  IDBITS  latched ID of the requesting or in-service source

Behaviour:
- Reset (init==0 at posedge):
  - state=IDLE, irq=0, irq_id=0, pend=0, mask=0, GIE=0.
  - Overrides every other event in the same cycle. A reset mid-REQ or mid-SERVICE discards the in-service source.
- Pending register: pend <= dev_intr every cycle. It is read-only; a write to PEND_ADDR is ignored.
- Eligibility: elig = pend & mask when GIE=1, else 0. Priority: lowest index wins. sel = index of lowest set bit of elig.
- State codes on CTRL[5:4]: IDLE=0, REQ=1, SERVICE=2.
- IDLE:
  - irq=0.
  - If elig!=0, go to REQ and latch irq_id<=sel.
- REQ:
  - irq=1. irq_id stays frozen; a higher-priority arrival does not replace it.
  - On a read of ID_ADDR (rdID = !we && abus==ID_ADDR): go to SERVICE, irq=0 from the next cycle.
  - Else if elig[irq_id]==0 (line dropped, masked, or GIE cleared): return to IDLE (withdrawn request).
  - If rdID and withdrawal occur in the same edge, rdID wins and the state goes to SERVICE.
- SERVICE:
  - irq=0. Mask, GIE and dev_intr changes have no effect on state.
  - A write to EOI_ADDR moves to IDLE. A new request can be latched on the following edge.
- EOI writes outside SERVICE are ignored. ID reads outside REQ/SERVICE do not change state.
- Reads (combinational, gated by !we and address match):
  - ID_ADDR: zero-extended irq_id in REQ/SERVICE; 32'hFFFFFFFF (spurious) in IDLE.
  - MASK_ADDR: {0, mask}.
  - PEND_ADDR: {0, pend}.
  - CTRL_ADDR: {0, state[1:0], 3'b0, GIE}.
- Writes (we && address match, sampled at posedge):
  - MASK_ADDR: mask <= dbus[NSRC-1:0].
  - CTRL_ADDR: GIE <= dbus[0]; other bits ignored.
- A multi-cycle ID read is valid: the first edge acknowledges, later cycles return the same in-service ID.
- Latency: dev_intr high before edge E0 -> pend set at E0 -> REQ at E1 -> irq=1 after E1. After the acknowledging edge, irq=0.
- Upper unused data bits always read 0. Unmapped addresses leave dbus high-Z.

Test Plan:
- Reset then idle: init=0 for 2 cycles -> irq=0; reads give ID=FFFFFFFF, MASK=0, CTRL=0.
- Basic flow: MASK=0x01, GIE=1, dev_intr[0]=1 -> irq=1 two edges later with irq_id=0; read ID -> 0, then irq=0 and CTRL[5:4]=2; write EOI -> CTRL[5:4]=0. With dev_intr[0] still high, irq re-asserts 2 edges later.
- Priority and freeze: MASK=0xFF, dev_intr=0x20 -> irq_id=5. Then raise dev_intr[2] while in REQ -> ID read still returns 5. After EOI (line 5 cleared) -> next request has irq_id=2.
- Withdrawal: in REQ with id=3, drop dev_intr[3] -> back to IDLE, irq=0, ID read returns FFFFFFFF. Repeat using GIE=0 -> same result.
- Masking and global enable: dev_intr=0x0F, MASK=0x00 -> no irq, PEND reads 0x0F. Set MASK=0x08 -> irq_id=3. With GIE=0 -> no irq.
- Reset mid-service: in SERVICE with id=1, pulse init=0 for one edge -> state IDLE, mask=0, irq=0, an EOI write afterward is ignored.
